// File: rtl/apple2_mem_pkg.sv
// Shared types and constants for the Apple II language-card memory path.
package apple2_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } lc_state_e;

  typedef enum logic [2:0] {
    RegionMain,
    RegionIo,
    RegionLcRam,
    RegionRom,
    RegionDiscard
  } region_e;

  localparam logic [15:0] IO_BASE   = 16'hC000;
  localparam logic [15:0] LC_BASE   = 16'hD000;
  localparam logic [7:0]  IDLE_DATA = 8'hFF;

  // Regions that need a transaction on the shared RAM controller.
  function automatic logic needs_mem(region_e region);
    return (region == RegionMain) || (region == RegionLcRam);
  endfunction

endpackage

// File: rtl/lc_mem_responder_if.sv
// Request/acknowledge bus between the responder and the shared RAM controller.
interface lc_mem_responder_if #(
  parameter int unsigned AW = 18
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lc_addr_classify.sv
// Combinational classification of a CPU access into the memory region that services it.
module lc_addr_classify
  import apple2_mem_pkg::*;
(
  input  logic [15:0] addr,
  input  logic        we,
  input  logic        card_ram_rd,
  input  logic        card_ram_we,
  output region_e     region
);

  always_comb begin
    region = RegionDiscard;
    if (addr < IO_BASE) begin
      region = RegionMain;
    end else if (addr < LC_BASE) begin
      region = RegionIo;
    end else if (!we) begin
      region = card_ram_rd ? RegionLcRam : RegionRom;
    end else begin
      // Writes to a write-protected card are dropped without a bus cycle.
      region = card_ram_we ? RegionLcRam : RegionDiscard;
    end
  end

endmodule

// File: rtl/lc_mem_responder.sv
// Memory-side responder: routes each CPU access to RAM, ROM, I/O or discard and
// runs the request/acknowledge transaction to the shared RAM controller.
module lc_mem_responder
  import apple2_mem_pkg::*;
#(
  parameter int unsigned AW      = 18,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      mclk28,
  input  logic                      reset_in,
  input  logic                      cpu_strobe,
  input  logic [15:0]               addr,
  input  logic                      we,
  input  logic [7:0]                din,
  input  logic [AW-1:0]             ram_addr,
  input  logic                      card_ram_rd,
  input  logic                      card_ram_we,
  input  logic [7:0]                rom_dout,
  lc_mem_responder_if.master        mem,
  output logic [7:0]                cpu_dout,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      overrun
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lc_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      dout_q, dout_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;
  region_e         region;

  lc_addr_classify u_classify (
    .addr        (addr),
    .we          (we),
    .card_ram_rd (card_ram_rd),
    .card_ram_we (card_ram_we),
    .region      (region)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    err_d   = err_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_strobe) begin
          if (needs_mem(region)) begin
            state_d = StReq;
            cnt_d   = '0;
            we_d    = we;
            addr_d  = ram_addr;
            wdata_d = din;
          end else if (region == RegionRom) begin
            dout_d = rom_dout;
          end
        end
      end
      StReq: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (mem.mem_ack) begin
          state_d = StDone;
          if (!we_q) dout_d = mem.mem_rdata;
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (!we_q) dout_d = IDLE_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (cpu_strobe && (state_q != StIdle)) ovr_d = 1'b1;
  end

  always_ff @(posedge mclk28 or posedge reset_in) begin
    if (reset_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= IDLE_DATA;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mem.mem_req   = (state_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign cpu_dout      = dout_q;
  assign busy          = (state_q != StIdle);
  assign timeout_err   = err_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_lc_mem_responder.sv
// Bench for lc_mem_responder: timestamp-based transaction model plus directed literal checks.
module tb_lc_mem_responder;

  localparam int TO = 15;
  localparam int R_MAIN = 0, R_IO = 1, R_LC = 2, R_ROM = 3, R_DISC = 4;

  logic        mclk28 = 1'b0;
  logic        reset_in;
  logic        cpu_strobe;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  din;
  logic [17:0] ram_addr;
  logic        card_ram_rd;
  logic        card_ram_we;
  logic [7:0]  rom_dout;
  logic [7:0]  cpu_dout;
  logic        busy;
  logic        timeout_err;
  logic        overrun;

  lc_mem_responder_if #(.AW(18)) mem_bus ();

  lc_mem_responder #(.AW(18), .TIMEOUT(TO)) dut (
    .mclk28      (mclk28),
    .reset_in    (reset_in),
    .cpu_strobe  (cpu_strobe),
    .addr        (addr),
    .we          (we),
    .din         (din),
    .ram_addr    (ram_addr),
    .card_ram_rd (card_ram_rd),
    .card_ram_we (card_ram_we),
    .rom_dout    (rom_dout),
    .mem         (mem_bus),
    .cpu_dout    (cpu_dout),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 mclk28 = ~mclk28;

  int n_checks = 0;
  int n_errors = 0;
  int s = 0;  // posedges since the last reset release

  // Model: one accepted transaction occupies mem_req for steps [act_k, act_k+act_l)
  // and busy for [act_k, act_k+act_l]; outcomes land at planned steps.
  int          act_k = -1000;
  int          act_l = 0;
  int          ack_step = -1;
  int          dout_at = -1;
  int          err_at = -1;
  logic        act_we;
  logic [17:0] act_addr;
  logic [7:0]  act_wdata;
  logic [7:0]  act_rdata;
  logic [7:0]  dout_new;
  logic [7:0]  dout_exp = 8'hFF;
  logic        err_exp = 1'b0;
  logic        ovr_exp = 1'b0;
  logic        ovr_next = 1'b0;

  // Next strobe to issue
  logic        nx_strobe = 1'b0;
  logic [15:0] nx_addr;
  logic        nx_we;
  logic [7:0]  nx_din;
  logic [17:0] nx_ram;
  logic        nx_rd;
  logic        nx_wr;
  logic [7:0]  nx_rom;
  int          nx_delay;
  logic [7:0]  nx_rdata;

  function automatic int region_of(logic [15:0] a, logic w, logic rd, logic wr);
    if (a < 16'hC000) return R_MAIN;
    if (a < 16'hD000) return R_IO;
    if (!w) return rd ? R_LC : R_ROM;
    return wr ? R_LC : R_DISC;
  endfunction

  function automatic bit in_req(int t);
    return (t >= act_k) && (t < act_k + act_l);
  endfunction

  function automatic bit in_busy(int t);
    return (t >= act_k) && (t <= act_k + act_l);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, s, act, want);
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", 32'(mem_bus.mem_req), 32'(in_req(s)));
    chk("busy", 32'(busy), 32'(in_busy(s)));
    chk("cpu_dout", 32'(cpu_dout), 32'(dout_exp));
    chk("timeout_err", 32'(timeout_err), 32'(err_exp));
    chk("overrun", 32'(overrun), 32'(ovr_exp));
    if (in_req(s)) begin
      chk("mem_addr", 32'(mem_bus.mem_addr), 32'(act_addr));
      chk("mem_we", 32'(mem_bus.mem_we), 32'(act_we));
      chk("mem_wdata", 32'(mem_bus.mem_wdata), 32'(act_wdata));
    end
  endtask

  task automatic stim(input logic [15:0] a, input logic w, input logic [7:0] d,
                      input logic [17:0] ra, input logic rd, input logic wr,
                      input logic [7:0] rom, input int delay, input logic [7:0] rdata);
    nx_strobe = 1'b1; nx_addr = a; nx_we = w; nx_din = d; nx_ram = ra;
    nx_rd = rd; nx_wr = wr; nx_rom = rom; nx_delay = delay; nx_rdata = rdata;
  endtask

  task automatic rand_stim();
    int sel;
    int r;
    sel = $urandom_range(0, 3);
    if (sel == 0) nx_addr = 16'($urandom_range(0, 32'hBFFF));
    else if (sel == 1) nx_addr = 16'($urandom_range(32'hC000, 32'hCFFF));
    else nx_addr = 16'($urandom_range(32'hD000, 32'hFFFF));
    r = $urandom_range(0, 9);
    if (r == 0) nx_delay = TO;
    else if (r == 1) nx_delay = TO + 1;
    else if (r == 2) nx_delay = $urandom_range(TO + 2, TO + 5);
    else nx_delay = $urandom_range(1, 6);
    nx_strobe = 1'b1;
    nx_we = 1'($urandom);
    nx_din = 8'($urandom);
    nx_ram = 18'($urandom);
    nx_rd = 1'($urandom);
    nx_wr = 1'($urandom);
    nx_rom = 8'($urandom);
    nx_rdata = 8'($urandom);
  endtask

  // Drive the inputs for the coming edge, advance one cycle, then compare.
  task automatic tick();
    int rg;
    if (nx_strobe) begin
      cpu_strobe = 1'b1; addr = nx_addr; we = nx_we; din = nx_din; ram_addr = nx_ram;
      card_ram_rd = nx_rd; card_ram_we = nx_wr; rom_dout = nx_rom;
      if (in_busy(s)) begin
        ovr_next = 1'b1;
      end else begin
        rg = region_of(nx_addr, nx_we, nx_rd, nx_wr);
        if (rg == R_MAIN || rg == R_LC) begin
          act_k = s + 1;
          act_l = (nx_delay <= TO) ? nx_delay : TO;
          act_we = nx_we; act_addr = nx_ram; act_wdata = nx_din; act_rdata = nx_rdata;
          // A delay of TO+1 puts a stray ack in the DONE cycle.
          ack_step = (nx_delay <= TO + 1) ? act_k + nx_delay - 1 : -1;
          if (nx_delay > TO) err_at = act_k + act_l;
          if (!nx_we) begin
            dout_at = act_k + act_l;
            dout_new = (nx_delay <= TO) ? nx_rdata : 8'hFF;
          end
        end else if (rg == R_ROM) begin
          dout_at = s + 1;
          dout_new = nx_rom;
        end
      end
    end else begin
      cpu_strobe = 1'b0; addr = 16'($urandom); we = 1'($urandom); din = 8'($urandom);
      ram_addr = 18'($urandom); card_ram_rd = 1'($urandom); card_ram_we = 1'($urandom);
      rom_dout = 8'($urandom);
    end
    if (s == ack_step) begin
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = act_rdata;
    end else if (!in_req(s) && $urandom_range(0, 7) == 0) begin
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 8'($urandom);
    end else begin
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 8'($urandom);
    end
    nx_strobe = 1'b0;
    @(negedge mclk28);
    s++;
    if (s == dout_at) dout_exp = dout_new;
    if (s == err_at) err_exp = 1'b1;
    if (ovr_next) begin
      ovr_exp = 1'b1;
      ovr_next = 1'b0;
    end
    check_outputs();
  endtask

  task automatic model_reset();
    act_k = -1000; act_l = 0; ack_step = -1; dout_at = -1; err_at = -1;
    dout_exp = 8'hFF; err_exp = 1'b0; ovr_exp = 1'b0; ovr_next = 1'b0; s = 0;
  endtask

  initial begin
    reset_in = 1'b1; cpu_strobe = 1'b0; addr = '0; we = 1'b0; din = '0; ram_addr = '0;
    card_ram_rd = 1'b0; card_ram_we = 1'b0; rom_dout = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    repeat (3) @(negedge mclk28);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'h0);
    chk("rst_mem_we", 32'(mem_bus.mem_we), 32'h0);
    chk("rst_mem_wdata", 32'(mem_bus.mem_wdata), 32'h0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_flags", 32'({timeout_err, overrun}), 32'h0);
    reset_in = 1'b0;
    model_reset();
    repeat (2) tick();

    // Main RAM read, ack in the 2nd REQ cycle
    stim(16'h0400, 1'b0, 8'h00, 18'h00400, 1'b0, 1'b0, 8'h00, 2, 8'h5A);
    tick();
    chk("main_req1", 32'(mem_bus.mem_req), 32'h1);
    chk("main_addr", 32'(mem_bus.mem_addr), 32'h00400);
    tick();
    chk("main_req2", 32'(mem_bus.mem_req), 32'h1);
    tick();
    chk("main_req_drop", 32'(mem_bus.mem_req), 32'h0);
    chk("main_dout", 32'(cpu_dout), 32'h5A);
    chk("main_busy_done", 32'(busy), 32'h1);
    tick();
    chk("main_busy_fall", 32'(busy), 32'h0);

    // Language-card RAM read, then ROM read at the same address
    stim(16'hD123, 1'b0, 8'h00, 18'h0C123, 1'b1, 1'b0, 8'h00, 1, 8'h3C);
    tick();
    chk("lc_addr", 32'(mem_bus.mem_addr), 32'h0C123);
    chk("lc_we", 32'(mem_bus.mem_we), 32'h0);
    tick();
    chk("lc_dout", 32'(cpu_dout), 32'h3C);
    tick();
    stim(16'hD123, 1'b0, 8'h00, 18'h0C123, 1'b0, 1'b0, 8'hA9, 1, 8'h00);
    tick();
    chk("rom_dout", 32'(cpu_dout), 32'hA9);
    chk("rom_no_req", 32'(mem_bus.mem_req | busy), 32'h0);

    // Write-protected card, then writable card
    stim(16'hE000, 1'b1, 8'h77, 18'h02000, 1'b0, 1'b0, 8'h00, 1, 8'h00);
    tick();
    chk("wp_no_req", 32'(mem_bus.mem_req), 32'h0);
    chk("wp_dout", 32'(cpu_dout), 32'hA9);
    tick();
    stim(16'hE000, 1'b1, 8'h77, 18'h02000, 1'b0, 1'b1, 8'h00, 3, 8'h00);
    tick();
    chk("wr_we", 32'(mem_bus.mem_we), 32'h1);
    chk("wr_wdata", 32'(mem_bus.mem_wdata), 32'h77);
    repeat (2) tick();
    chk("wr_hold", 32'({mem_bus.mem_req, mem_bus.mem_wdata}), 32'h177);
    tick();
    chk("wr_drop", 32'(mem_bus.mem_req), 32'h0);
    chk("wr_dout", 32'(cpu_dout), 32'hA9);
    tick();

    // Ack in the final cycle before expiry wins over the timeout
    stim(16'h0800, 1'b0, 8'h00, 18'h00800, 1'b0, 1'b0, 8'h00, TO, 8'hC3);
    repeat (TO + 1) tick();
    chk("ack15_drop", 32'(mem_bus.mem_req), 32'h0);
    chk("ack15_no_err", 32'(timeout_err), 32'h0);
    chk("ack15_dout", 32'(cpu_dout), 32'hC3);
    tick();

    // Timeout with no ack at all
    stim(16'h0800, 1'b0, 8'h00, 18'h00800, 1'b0, 1'b0, 8'h00, TO + 5, 8'h00);
    repeat (TO) tick();
    chk("to_req_last", 32'(mem_bus.mem_req), 32'h1);
    tick();
    chk("to_drop", 32'(mem_bus.mem_req), 32'h0);
    chk("to_err", 32'(timeout_err), 32'h1);
    chk("to_dout", 32'(cpu_dout), 32'hFF);
    repeat (2) tick();
    chk("to_sticky", 32'(timeout_err), 32'h1);

    // Overrun: second strobe during REQ is ignored
    stim(16'h0400, 1'b0, 8'h00, 18'h00123, 1'b0, 1'b0, 8'h00, 4, 8'h11);
    tick();
    chk("ovr_before", 32'(overrun), 32'h0);
    stim(16'h1234, 1'b0, 8'h00, 18'h01234, 1'b0, 1'b0, 8'h00, 1, 8'h99);
    tick();
    chk("ovr_set", 32'(overrun), 32'h1);
    repeat (3) tick();
    chk("ovr_first_data", 32'(cpu_dout), 32'h11);
    repeat (2) tick();

    // Soft-switch I/O access
    stim(16'hC08B, 1'b0, 8'h00, 18'h0C08B, 1'b1, 1'b1, 8'h00, 1, 8'h00);
    tick();
    chk("io_idle", 32'({mem_bus.mem_req, busy}), 32'h0);
    tick();

    // Asynchronous reset in the middle of a write request
    stim(16'h0400, 1'b1, 8'h05, 18'h00400, 1'b0, 1'b0, 8'h00, TO + 5, 8'h00);
    repeat (2) tick();
    chk("arst_pre_req", 32'(mem_bus.mem_req), 32'h1);
    #7 reset_in = 1'b1;
    #1;
    chk("arst_req", 32'(mem_bus.mem_req), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_dout", 32'(cpu_dout), 32'hFF);
    chk("arst_flags", 32'({timeout_err, overrun}), 32'h0);
    mem_bus.mem_ack = 1'b0;
    @(negedge mclk28);
    reset_in = 1'b0;
    model_reset();
    check_outputs();

    repeat (3000) begin
      if ($urandom_range(0, 2) == 0) rand_stim();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
